// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the DPWM input conditioner.
// Edge pulses are built only when INPUT_COND_EDGE_EN is defined.
package input_cond_pkg;

   localparam int DEF_N_CH        = 2;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DEB_CYCLES  = 16;

   // Bits needed to hold 0..deb_cycles, i.e. clog2(deb_cycles+1).
   function automatic int cnt_width(input int deb_cycles);
      int w;
      w = 1;
      while ((1 << w) < (deb_cycles + 1)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One data channel: synchroniser chain, stability counter, held level.
// Rise/fall pulse flops exist only when INPUT_COND_EDGE_EN is defined.
module input_cond_channel
   import input_cond_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W = cnt_width(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   level_q;
   logic                   level_d;
   logic                   sync_lvl;
   logic                   accept;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], pin_i};
   assign sync_lvl = sync_q[SYNC_STAGES-1];

   // Counter tracks how long the synced level has disagreed with the held one.
   always_comb begin
      cnt_d  = cnt_q;
      accept = 1'b0;
      if (sync_lvl == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         accept = 1'b1;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign level_d = accept ? sync_lvl : level_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;

`ifdef INPUT_COND_EDGE_EN
   logic rise_q;
   logic fall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= accept & sync_lvl;
         fall_q <= accept & ~sync_lvl;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;
`else
   assign rise_o = 1'b0;
   assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// DPWM control-input front end: N_CH debounced channels plus synced select.
// Define INPUT_COND_EDGE_EN to build the dato_rise/dato_fall pulse flops.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
   input  logic            clkm,
   input  logic            reset,
   input  logic [N_CH-1:0] datoin,
   input  logic            selin,
   output logic [N_CH-1:0] datoout,
   output logic [N_CH-1:0] dato_rise,
   output logic [N_CH-1:0] dato_fall,
   output logic            selout
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      input_cond_channel #(
         .SYNC_STAGES(SYNC_STAGES),
         .DEB_CYCLES (DEB_CYCLES)
      ) u_ch (
         .clk_i  (clkm),
         .rst_i  (reset),
         .pin_i  (datoin[i]),
         .level_o(datoout[i]),
         .rise_o (dato_rise[i]),
         .fall_o (dato_fall[i])
      );
   end

   // Select is passed through a plain synchroniser, no debounce.
   logic [SYNC_STAGES-1:0] sel_sync_q;
   logic [SYNC_STAGES-1:0] sel_sync_d;

   assign sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], selin};

   always_ff @(posedge clkm) begin
      if (reset) begin
         sel_sync_q <= '0;
      end else begin
         sel_sync_q <= sel_sync_d;
      end
   end

   assign selout = sel_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (N_CH=4, SYNC_STAGES=2, DEB_CYCLES=16).
// Pulse expectations collapse to 0 when INPUT_COND_EDGE_EN is undefined.
module tb_input_conditioner;

   localparam int NC = 4;
   localparam int SS = 2;
   localparam int DC = 16;

`ifdef INPUT_COND_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [NC-1:0] din;
   logic          sel;
   logic [NC-1:0] dout;
   logic [NC-1:0] rise;
   logic [NC-1:0] fall;
   logic          selo;

   int n_tests = 0;
   int n_fail  = 0;
   int rise_cnt [NC];
   int fall_cnt [NC];

   always #5 clk = ~clk;

   input_conditioner #(
      .N_CH       (NC),
      .SYNC_STAGES(SS),
      .DEB_CYCLES (DC)
   ) dut (
      .clkm     (clk),
      .reset    (reset),
      .datoin   (din),
      .selin    (sel),
      .datoout  (dout),
      .dato_rise(rise),
      .dato_fall(fall),
      .selout   (selo)
   );

   // Pulses span a full cycle, so the falling edge sees each exactly once.
   initial begin
      for (int i = 0; i < NC; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NC; i++) begin
         if (rise[i] === 1'b1) rise_cnt[i] = rise_cnt[i] + 1;
         if (fall[i] === 1'b1) fall_cnt[i] = fall_cnt[i] + 1;
      end
   end

   typedef struct {
      string         name;
      logic [NC-1:0] din;
      logic          sel;
      int            steps;
      logic [NC-1:0] dout;
      logic [NC-1:0] rise;
      logic [NC-1:0] fall;
      logic          selo;
   } vec_t;

   vec_t vq[$];

   function automatic void add(string nm, logic [NC-1:0] d, logic s, int n,
                               logic [NC-1:0] ed, logic [NC-1:0] er,
                               logic [NC-1:0] ef, logic es);
      vec_t v;
      v.name  = nm;
      v.din   = d;
      v.sel   = s;
      v.steps = n;
      v.dout  = ed;
      v.rise  = EDGE ? er : '0;
      v.fall  = EDGE ? ef : '0;
      v.selo  = es;
      vq.push_back(v);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [NC-1:0] ed,
                        input logic [NC-1:0] er, input logic [NC-1:0] ef,
                        input logic es);
      n_tests++;
      if (dout !== ed || rise !== er || fall !== ef || selo !== es) begin
         n_fail++;
         $display("FAIL %s: got dout=%b rise=%b fall=%b sel=%b, want dout=%b rise=%b fall=%b sel=%b",
                  nm, dout, rise, fall, selo, ed, er, ef, es);
      end
   endtask

   function automatic logic [NC-1:0] pm(logic [NC-1:0] m);
      return EDGE ? m : '0;
   endfunction

   int exp_rise [NC];
   int exp_fall [NC];

   initial begin
      // Fresh state: dout=1111 from the reset scenario, pins then dropped.
      add("all_low_pre",  4'b0000, 1'b0, 17, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      add("all_low_edge", 4'b0000, 1'b0,  1, 4'b0000, 4'b0000, 4'b1111, 1'b0);
      add("all_low_end",  4'b0000, 1'b0,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add("glitch15_hi",  4'b0001, 1'b0, 15, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add("glitch15_lo",  4'b0000, 1'b0, 20, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add("rise1_pre",    4'b0010, 1'b0, 17, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add("rise1_edge",   4'b0010, 1'b0,  1, 4'b0010, 4'b0010, 4'b0000, 1'b0);
      add("rise1_after",  4'b0010, 1'b0,  1, 4'b0010, 4'b0000, 4'b0000, 1'b0);
      add("fall1_pre",    4'b0000, 1'b0, 17, 4'b0010, 4'b0000, 4'b0000, 1'b0);
      add("fall1_edge",   4'b0000, 1'b0,  1, 4'b0000, 4'b0000, 4'b0010, 1'b0);
      add("fall1_after",  4'b0000, 1'b0,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add("indep_pre",    4'b1001, 1'b1, 17, 4'b0000, 4'b0000, 4'b0000, 1'b1);
      add("indep_edge",   4'b1001, 1'b1,  1, 4'b1001, 4'b1001, 4'b0000, 1'b1);
      add("indep_after",  4'b1001, 1'b1,  1, 4'b1001, 4'b0000, 4'b0000, 1'b1);
      add("exact16_hi",   4'b1011, 1'b1, 16, 4'b1001, 4'b0000, 4'b0000, 1'b1);
      add("exact16_acc",  4'b1001, 1'b1,  2, 4'b1011, 4'b0010, 4'b0000, 1'b1);
      add("exact16_hold", 4'b1001, 1'b1, 15, 4'b1011, 4'b0000, 4'b0000, 1'b1);
      add("exact16_fall", 4'b1001, 1'b1,  1, 4'b1001, 4'b0000, 4'b0010, 1'b1);
      add("settle_edge",  4'b0000, 1'b1, 18, 4'b0000, 4'b0000, 4'b1001, 1'b1);
      add("settle_end",   4'b0000, 1'b1,  1, 4'b0000, 4'b0000, 4'b0000, 1'b1);

      // Reset held with all pins high: outputs stay low throughout.
      reset = 1'b1;
      din   = 4'b1111;
      sel   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("in_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      reset = 1'b0;
      step(1);
      check("sel_lat1", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      step(1);
      check("sel_lat2", 4'b0000, 4'b0000, 4'b0000, 1'b1);
      step(15);
      check("rst_rise_pre", 4'b0000, 4'b0000, 4'b0000, 1'b1);
      step(1);
      check("rst_rise", 4'b1111, pm(4'b1111), 4'b0000, 1'b1);
      step(1);
      check("rst_rise_end", 4'b1111, 4'b0000, 4'b0000, 1'b1);

      foreach (vq[i]) begin
         din = vq[i].din;
         sel = vq[i].sel;
         step(vq[i].steps);
         check(vq[i].name, vq[i].dout, vq[i].rise, vq[i].fall, vq[i].selo);
      end

      // Reset lands while ch0 has counted 10 cycles of a pending rise.
      din = 4'b0001;
      step(12);
      check("mid_pre", 4'b0000, 4'b0000, 4'b0000, 1'b1);
      reset = 1'b1;
      step(2);
      check("mid_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      reset = 1'b0;
      step(17);
      check("mid_restart_pre", 4'b0000, 4'b0000, 4'b0000, 1'b1);
      step(1);
      check("mid_restart", 4'b0001, pm(4'b0001), 4'b0000, 1'b1);
      step(1);
      check("mid_restart_end", 4'b0001, 4'b0000, 4'b0000, 1'b1);

      exp_rise = '{3, 3, 1, 2};
      exp_fall = '{2, 3, 1, 2};
      for (int i = 0; i < NC; i++) begin
         n_tests++;
         if (rise_cnt[i] != (EDGE ? exp_rise[i] : 0) ||
             fall_cnt[i] != (EDGE ? exp_fall[i] : 0)) begin
            n_fail++;
            $display("FAIL pulse_count ch%0d: got rise=%0d fall=%0d, want rise=%0d fall=%0d",
                     i, rise_cnt[i], fall_cnt[i],
                     EDGE ? exp_rise[i] : 0, EDGE ? exp_fall[i] : 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
